// File: rtl/fifo_wconv.sv
// Width-down-converting FIFO: stores RATIO*OUT_W-bit words and emits them as
// RATIO slices of OUT_W bits under downstream ready flow control.
module fifo_wconv #(
  parameter int OUT_W     = 8,
  parameter int RATIO     = 2,
  parameter int DEPTH     = 64,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [RATIO*OUT_W-1:0]     data_in,
  input  logic                       data_in_vld,
  output logic                       data_in_rdy,
  output logic [OUT_W-1:0]           data_out,
  output logic                       data_out_vld,
  input  logic                       b_rdy,
  output logic [$clog2(DEPTH):0]     fifo_cnt,
  output logic                       ovf
);

  localparam int IN_W = RATIO * OUT_W;
  localparam int AW   = $clog2(DEPTH);
  localparam int IW   = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  logic [IN_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     cnt;
  state_t          state, state_nxt;
  logic [IN_W-1:0] sreg, sreg_nxt, sreg_shifted;
  logic [IW-1:0]   idx, idx_nxt;
  logic            wr, load, xfer, last, not_empty;

  assign data_in_rdy  = (cnt != (AW+1)'(DEPTH));
  assign data_out_vld = (state == SEND);
  assign fifo_cnt     = cnt;

  assign wr        = data_in_vld && data_in_rdy;
  assign xfer      = data_out_vld && b_rdy;
  assign last      = (idx == IW'(RATIO - 1));
  assign not_empty = (cnt != '0);

  // Slices are always taken from the same end of the shift register, which
  // moves toward that end after each transfer.
  generate
    if (MSB_FIRST) begin : g_msb
      assign data_out     = sreg[IN_W-1 -: OUT_W];
      assign sreg_shifted = sreg << OUT_W;
    end else begin : g_lsb
      assign data_out     = sreg[OUT_W-1:0];
      assign sreg_shifted = sreg >> OUT_W;
    end
  endgenerate

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    idx_nxt   = idx;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (not_empty) begin
          load      = 1'b1;
          sreg_nxt  = mem[rptr];
          idx_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (!last) begin
            sreg_nxt = sreg_shifted;
            idx_nxt  = idx + IW'(1);
          end else if (not_empty) begin
            load     = 1'b1;
            sreg_nxt = mem[rptr];
            idx_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      idx   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      idx   <= idx_nxt;
      ovf   <= data_in_vld && !data_in_rdy;
      if (wr)   wptr <= wptr + AW'(1);
      if (load) rptr <= rptr + AW'(1);
      unique case ({wr, load})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale contents are unreachable
  // because the pointers and count are cleared, and omitting the reset lets
  // it map onto RAM.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= data_in;
  end

endmodule

// File: tb/tb_fifo_wconv.sv
// Self-checking bench for fifo_wconv: a queue-level reference model checked
// every cycle, plus directed scenario tasks with randomized data.
module tb_fifo_wconv;

  localparam int OUT_W = 8;
  localparam int RATIO = 2;
  localparam int DEPTH = 64;
  localparam bit MSB_FIRST = 1'b1;
  localparam int IN_W = OUT_W * RATIO;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [IN_W-1:0]        din = '0;
  logic                   din_vld = 1'b0;
  logic                   din_rdy;
  logic [OUT_W-1:0]       dout;
  logic                   dout_vld;
  logic                   b_rdy = 1'b0;
  logic [$clog2(DEPTH):0] cnt;
  logic                   ovf;

  fifo_wconv #(.OUT_W(OUT_W), .RATIO(RATIO), .DEPTH(DEPTH), .MSB_FIRST(MSB_FIRST)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(din), .data_in_vld(din_vld), .data_in_rdy(din_rdy),
    .data_out(dout), .data_out_vld(dout_vld), .b_rdy(b_rdy), .fifo_cnt(cnt), .ovf(ovf)
  );

  // Second instance: 32-bit words, four byte slices, least significant first.
  logic [31:0] din2 = '0;
  logic        din2_vld = 1'b0;
  logic        din2_rdy;
  logic [7:0]  dout2;
  logic        dout2_vld;
  logic        b2_rdy = 1'b1;
  logic [6:0]  cnt2;
  logic        ovf2;

  fifo_wconv #(.OUT_W(8), .RATIO(4), .DEPTH(64), .MSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .data_in(din2), .data_in_vld(din2_vld), .data_in_rdy(din2_rdy),
    .data_out(dout2), .data_out_vld(dout2_vld), .b_rdy(b2_rdy), .fifo_cnt(cnt2), .ovf(ovf2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: words in storage, slices left of the word in the unpacker.
  logic [IN_W-1:0]  m_store[$];
  logic [OUT_W-1:0] m_slices[$];
  logic             m_ovf = 1'b0;

  task automatic m_load();
    logic [IN_W-1:0] w;
    w = m_store.pop_front();
    for (int i = 0; i < RATIO; i++) begin
      if (MSB_FIRST) m_slices.push_back(OUT_W'(w >> (OUT_W * (RATIO - 1 - i))));
      else           m_slices.push_back(OUT_W'(w >> (OUT_W * i)));
    end
  endtask

  task automatic m_step();
    bit accept;
    accept = din_vld && (m_store.size() != DEPTH);
    m_ovf  = din_vld && (m_store.size() == DEPTH);
    if (m_slices.size() == 0) begin
      if (m_store.size() > 0) m_load();
    end else if (b_rdy) begin
      void'(m_slices.pop_front());
      if (m_slices.size() == 0 && m_store.size() > 0) m_load();
    end
    if (accept) m_store.push_back(din);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_store.delete();
      m_slices.delete();
      m_ovf = 1'b0;
    end else begin
      m_step();
    end
  end

  // Per-cycle comparison of the DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (dout_vld !== (m_slices.size() != 0)) begin
        errors++;
        $display("FAIL mon_vld t=%0t got %b want %b", $time, dout_vld, m_slices.size() != 0);
      end
      checks++;
      if (cnt !== ($clog2(DEPTH)+1)'(m_store.size())) begin
        errors++;
        $display("FAIL mon_cnt t=%0t got %0d want %0d", $time, cnt, m_store.size());
      end
      checks++;
      if (din_rdy !== (m_store.size() != DEPTH)) begin
        errors++;
        $display("FAIL mon_rdy t=%0t got %b want %b", $time, din_rdy, m_store.size() != DEPTH);
      end
      checks++;
      if (ovf !== m_ovf) begin
        errors++;
        $display("FAIL mon_ovf t=%0t got %b want %b", $time, ovf, m_ovf);
      end
      if (m_slices.size() != 0) begin
        checks++;
        if (dout !== m_slices[0]) begin
          errors++;
          $display("FAIL mon_data t=%0t got %h want %h", $time, dout, m_slices[0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    checks++;
    if (dout_vld !== 1'b0 || dout !== '0 || din_rdy !== 1'b1 || cnt !== '0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got vld=%b data=%h rdy=%b cnt=%0d ovf=%b want 0 00 1 0 0",
               dout_vld, dout, din_rdy, cnt, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill_drain();
    int ovf_hits = 0;
    logic [15:0] w;
    logic [7:0] exp_b;
    b_rdy = 1'b0;
    for (int k = 0; k < 61; k++) begin
      din = 16'(1000 + k);
      din_vld = 1'b1;
      step();
      if (ovf) ovf_hits++;
    end
    din_vld = 1'b0;
    checks++;
    if (ovf_hits !== 0) begin
      errors++;
      $display("FAIL fill_no_ovf got %0d pulses want 0", ovf_hits);
    end
    checks++;
    if (dout !== 8'h03 || dout_vld !== 1'b1 || cnt !== 7'd60) begin
      errors++;
      $display("FAIL fill_state got data=%h vld=%b cnt=%0d want 03 1 60", dout, dout_vld, cnt);
    end
    b_rdy = 1'b1;
    for (int i = 0; i < 122; i++) begin
      w = 16'(1000 + i / 2);
      exp_b = (i % 2 == 0) ? w[15:8] : w[7:0];
      checks++;
      if (dout_vld !== 1'b1 || dout !== exp_b) begin
        errors++;
        $display("FAIL drain_byte[%0d] got vld=%b data=%h want 1 %h", i, dout_vld, dout, exp_b);
      end
      step();
    end
    checks++;
    if (dout_vld !== 1'b0 || cnt !== '0) begin
      errors++;
      $display("FAIL drain_empty got vld=%b cnt=%0d want 0 0", dout_vld, cnt);
    end
    b_rdy = 1'b0;
  endtask

  task automatic test_overflow();
    int ovf_hits = 0;
    b_rdy = 1'b0;
    for (int k = 0; k < 70; k++) begin
      din = 16'(k);
      din_vld = 1'b1;
      step();
      if (ovf) ovf_hits++;
    end
    din_vld = 1'b0;
    step();
    if (ovf) ovf_hits++;
    checks++;
    if (ovf_hits !== 5) begin
      errors++;
      $display("FAIL ovf_pulses got %0d want 5", ovf_hits);
    end
    checks++;
    if (cnt !== 7'd64 || din_rdy !== 1'b0 || dout !== 8'h00 || dout_vld !== 1'b1) begin
      errors++;
      $display("FAIL full_state got cnt=%0d rdy=%b data=%h vld=%b want 64 0 00 1", cnt, din_rdy, dout, dout_vld);
    end
  endtask

  task automatic test_full_simul();
    b_rdy = 1'b1;
    step();
    din = 16'd999;
    din_vld = 1'b1;
    step();
    din_vld = 1'b0;
    b_rdy = 1'b0;
    checks++;
    if (ovf !== 1'b1 || cnt !== 7'd63 || din_rdy !== 1'b1) begin
      errors++;
      $display("FAIL full_simul got ovf=%b cnt=%0d rdy=%b want 1 63 1", ovf, cnt, din_rdy);
    end
    step();
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL full_simul_ovf_clear got %b want 0", ovf);
    end
  endtask

  task automatic test_drain();
    int cyc = 0;
    b_rdy = 1'b1;
    while ((dout_vld || cnt != 0) && cyc < 400) begin
      step();
      cyc++;
    end
    checks++;
    if (dout_vld !== 1'b0 || cnt !== '0) begin
      errors++;
      $display("FAIL drain_timeout got vld=%b cnt=%0d after %0d cycles want 0 0", dout_vld, cnt, cyc);
    end
    b_rdy = 1'b0;
  endtask

  task automatic test_lsb_ratio4();
    logic [31:0] w;
    logic [7:0]  exp_b;
    w = 32'h11223344;
    din2 = w;
    din2_vld = 1'b1;
    b2_rdy = 1'b1;
    step();
    din2_vld = 1'b0;
    checks++;
    if (dout2_vld !== 1'b0) begin
      errors++;
      $display("FAIL lsb_latency got vld=%b want 0 right after accept", dout2_vld);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      exp_b = 8'(w >> (8 * i));
      checks++;
      if (dout2_vld !== 1'b1 || dout2 !== exp_b) begin
        errors++;
        $display("FAIL lsb_slice[%0d] got vld=%b data=%h want 1 %h", i, dout2_vld, dout2, exp_b);
      end
    end
    step();
    checks++;
    if (dout2_vld !== 1'b0) begin
      errors++;
      $display("FAIL lsb_done got vld=%b want 0", dout2_vld);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got[$];
    logic [7:0] prev;
    bit hold = 1'b0;
    int widx = 0;
    int cyc = 0;
    b_rdy = 1'b1;
    while (got.size() < 40 && cyc < 400) begin
      if (widx < 20) begin
        din = {8'(2 * widx + 1), 8'(2 * widx + 2)};
        din_vld = 1'b1;
        widx++;
      end else begin
        din_vld = 1'b0;
      end
      b_rdy = ~b_rdy;
      if (hold) begin
        checks++;
        if (dout !== prev) begin
          errors++;
          $display("FAIL stall_stable cyc=%0d got %h want %h", cyc, dout, prev);
        end
      end
      hold = dout_vld && !b_rdy;
      prev = dout;
      if (dout_vld && b_rdy) got.push_back(dout);
      step();
      cyc++;
    end
    din_vld = 1'b0;
    b_rdy = 1'b0;
    checks++;
    if (got.size() != 40) begin
      errors++;
      $display("FAIL b2b_count got %0d bytes want 40", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 8'(i + 1)) begin
        errors++;
        $display("FAIL b2b_byte[%0d] got %h want %h", i, got[i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_random();
    int cyc = 0;
    for (int i = 0; i < 600; i++) begin
      din = 16'($urandom);
      din_vld = ($urandom_range(0, 3) != 0);
      b_rdy = ($urandom_range(0, 2) == 0);
      step();
    end
    din_vld = 1'b0;
    test_drain();
  endtask

  task automatic test_reset_mid();
    b_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      din = 16'($urandom);
      din_vld = 1'b1;
      step();
    end
    din_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout_vld !== 1'b0 || dout !== '0 || din_rdy !== 1'b1 || cnt !== '0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got vld=%b data=%h rdy=%b cnt=%0d ovf=%b want 0 00 1 0 0",
               dout_vld, dout, din_rdy, cnt, ovf);
    end
    b_rdy = 1'b0;
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (dout_vld !== 1'b0 || cnt !== '0) begin
      errors++;
      $display("FAIL reset_no_stale got vld=%b cnt=%0d want 0 0", dout_vld, cnt);
    end
    din = 16'hBEEF;
    din_vld = 1'b1;
    step();
    din_vld = 1'b0;
    step();
    checks++;
    if (dout_vld !== 1'b1 || dout !== 8'hBE) begin
      errors++;
      $display("FAIL reset_new_word got vld=%b data=%h want 1 be", dout_vld, dout);
    end
    test_drain();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_simul();
    test_drain();
    test_lsb_ratio4();
    test_back_to_back();
    test_drain();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
